gem_cluster_packer: RTL

Upstream neighbour of the trigger-fiber transmitter. It accepts the serial cluster stream from the S-bit cluster finder at 80 MHz and buffers it in a small FIFO. Once per bunch crossing it packs up to four clusters into the 56-bit frame word (GEM_DATA) that the fiber stage serialises. It flags GEM_OVERFLOW when clusters could not be carried in the current frame.

---
 rtl/gem_cluster_packer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gem_cluster_packer.sv
// gem_cluster_packer
// Buffers the serial S-bit cluster stream in a small circular FIFO and, on
// every frame strobe, packs up to four of the oldest clusters into the 56-bit
// frame word for the fiber transmitter. Unused slots carry EMPTY_WORD. An
// overflow flag marks frames that left clusters behind or followed a drop.
module gem_cluster_packer #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [13:0] EMPTY_WORD = 14'h3FFF
) (
  input  logic        TRG_CLK80,
  input  logic        TRG_RST,
  input  logic        FRAME_STROBE,
  input  logic        CLU_VALID,
  input  logic [13:0] CLU_DATA,
  output logic [55:0] GEM_DATA,
  output logic        GEM_OVERFLOW,
  output logic [3:0]  OCCUPANCY,
  output logic [15:0] DROP_CNT
);

  // Pointer width covers 0..FIFO_DEPTH-1; one extra bit holds ptr+offset sums.
  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_P = (PW+1)'(FIFO_DEPTH);
  localparam logic [4:0]    DEPTH_5 = 5'(FIFO_DEPTH);

  // Wrap a pointer sum back into 0..FIFO_DEPTH-1. Sums never exceed
  // 2*FIFO_DEPTH-1 because offsets are at most 4 and depth is at least 4.
  function automatic logic [PW-1:0] ptr_wrap(input logic [PW:0] sum);
    logic [PW-1:0] res;
    if (sum >= DEPTH_P) begin
      res = PW'(sum - DEPTH_P);
    end else begin
      res = sum[PW-1:0];
    end
    return res;
  endfunction

  logic [13:0]   mem_q [FIFO_DEPTH];
  logic [13:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]    occ_q, occ_d;
  logic [55:0]   gem_data_q, gem_data_d;
  logic          overflow_q, overflow_d;
  logic          drop_pending_q, drop_pending_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic [2:0]    pop_s;
  logic [3:0]    rem_s;
  logic          wr_ok_s;
  logic          drop_s;
  logic [55:0]   frame_s;

  // Pop count, post-pop occupancy and write acceptance for this edge.
  always_comb begin
    pop_s = 3'd0;
    if (FRAME_STROBE) begin
      if (occ_q > 4'd4) begin
        pop_s = 3'd4;
      end else begin
        pop_s = occ_q[2:0];
      end
    end else begin
      pop_s = 3'd0;
    end
    rem_s   = occ_q - {1'b0, pop_s};
    wr_ok_s = CLU_VALID && ({1'b0, rem_s} < DEPTH_5);
    drop_s  = CLU_VALID && !wr_ok_s;
  end

  // Assemble the frame candidate: popped entries oldest-first, filler after.
  always_comb begin
    frame_s = {4{EMPTY_WORD}};
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < pop_s) begin
        frame_s[i*14 +: 14] = mem_q[ptr_wrap({1'b0, rd_ptr_q} + (PW+1)'(i))];
      end else begin
        frame_s[i*14 +: 14] = EMPTY_WORD;
      end
    end
  end

  // Next-state for FIFO storage, pointers and occupancy. The incoming cluster
  // is appended after the pops, so it never joins the frame built this edge.
  always_comb begin
    mem_d    = mem_q;
    occ_d    = rem_s + {3'b000, wr_ok_s};
    rd_ptr_d = ptr_wrap({1'b0, rd_ptr_q} + (PW+1)'(pop_s));
    if (wr_ok_s) begin
      mem_d[wr_ptr_q] = CLU_DATA;
      wr_ptr_d        = ptr_wrap({1'b0, wr_ptr_q} + {{PW{1'b0}}, 1'b1});
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
  end

  // Next-state for the frame outputs, drop bookkeeping and overflow flag.
  always_comb begin
    gem_data_d     = gem_data_q;
    overflow_d     = overflow_q;
    drop_pending_d = drop_pending_q;
    if (FRAME_STROBE) begin
      gem_data_d     = frame_s;
      overflow_d     = (rem_s != 4'd0) || drop_pending_q || drop_s;
      drop_pending_d = 1'b0;
    end else begin
      drop_pending_d = drop_pending_q || drop_s;
    end
    if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State registers; reset flushes the FIFO and restores an all-empty frame.
  always_ff @(posedge TRG_CLK80 or posedge TRG_RST) begin
    if (TRG_RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 14'h0000;
      end
      rd_ptr_q       <= {PW{1'b0}};
      wr_ptr_q       <= {PW{1'b0}};
      occ_q          <= 4'd0;
      gem_data_q     <= {4{EMPTY_WORD}};
      overflow_q     <= 1'b0;
      drop_pending_q <= 1'b0;
      drop_cnt_q     <= 16'h0000;
    end else begin
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      occ_q          <= occ_d;
      gem_data_q     <= gem_data_d;
      overflow_q     <= overflow_d;
      drop_pending_q <= drop_pending_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign GEM_DATA     = gem_data_q;
  assign GEM_OVERFLOW = overflow_q;
  assign OCCUPANCY    = occ_q;
  assign DROP_CNT     = drop_cnt_q;

endmodule
